// File: rtl/uaslr_region_remap.sv
// rtl/uaslr_region_remap.sv - micro-ASLR region remapper with LFSR offsets and drain/swap re-key FSM
// Optional feature: define UASLR_REKEY_TIMER_EN to add a periodic internal re-key timer.
module uaslr_region_remap #(
    parameter int                   ADDR_WIDTH  = 32,
    parameter int                   NUM_REGIONS = 4,
    parameter int                   RNG_WIDTH   = 32,
    parameter logic [RNG_WIDTH-1:0] LFSR_POLY   = 32'h80200003,
    parameter logic [RNG_WIDTH-1:0] OFFSET_MASK = 32'h00000FFC,
    parameter int                   MAX_OUTST   = 4
`ifdef UASLR_REKEY_TIMER_EN
    ,
    parameter int                   REKEY_PERIOD = 4096
`endif
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_en_i,
    input  logic [RNG_WIDTH-1:0]              cfg_seed_i,
    input  logic                              cfg_seed_ld_i,
    input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] region_base_i,
    input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] region_limit_i,
    input  logic                              rekey_req_i,
    output logic                              rekey_busy_o,
    input  logic                              instr_req_i,
    input  logic [ADDR_WIDTH-1:0]             instr_addr_i,
    output logic                              instr_gnt_o,
    input  logic                              instr_rvalid_i,
    output logic                              instr_req_o,
    output logic [ADDR_WIDTH-1:0]             instr_addr_o,
    input  logic                              instr_gnt_i,
    input  logic                              data_req_i,
    input  logic [ADDR_WIDTH-1:0]             data_addr_i,
    output logic                              data_gnt_o,
    input  logic                              data_rvalid_i,
    output logic                              data_req_o,
    output logic [ADDR_WIDTH-1:0]             data_addr_o,
    input  logic                              data_gnt_i
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int IW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam logic [RNG_WIDTH-1:0] OFF_MASK = OFFSET_MASK & ~RNG_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SWAP
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q;
    logic [RNG_WIDTH-1:0]   lfsr_q, lfsr_nxt, seed_fix, seed_pend_q;
    logic                   seed_pend_valid_q;
    logic [ADDR_WIDTH-1:0]  offset_q [NUM_REGIONS];
    logic [CW-1:0]          instr_outst_q, data_outst_q;
    logic                   busy, timer_req, rekey_req;
    logic                   instr_stall, data_stall, instr_inc, data_inc;

    assign busy         = (state_q != ST_IDLE);
    assign rekey_busy_o = busy;
    assign rekey_req    = rekey_req_i | timer_req;

`ifdef UASLR_REKEY_TIMER_EN
    localparam int TW = (REKEY_PERIOD > 1) ? $clog2(REKEY_PERIOD) : 1;
    logic [TW-1:0] timer_q;

    assign timer_req = !busy && (timer_q == TW'(REKEY_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst || busy || timer_req) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TW'(1);
        end
    end
`else
    assign timer_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (rekey_req) state_d = ST_DRAIN;
            ST_DRAIN: if (instr_outst_q == '0 && data_outst_q == '0) state_d = ST_SWAP;
            ST_SWAP:  if (idx_q == IW'(NUM_REGIONS - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
    assign seed_fix = (cfg_seed_i == '0) ? RNG_WIDTH'(1) : cfg_seed_i;

    // Seed loads arriving mid re-key are parked and applied on the first idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q            <= RNG_WIDTH'(1);
            seed_pend_q       <= '0;
            seed_pend_valid_q <= 1'b0;
            idx_q             <= '0;
            for (int k = 0; k < NUM_REGIONS; k++) offset_q[k] <= '0;
        end else begin
            if (state_q == ST_DRAIN) begin
                idx_q <= '0;
            end
            if (state_q == ST_SWAP) begin
                offset_q[idx_q] <= ADDR_WIDTH'(lfsr_nxt & OFF_MASK);
                lfsr_q          <= lfsr_nxt;
                idx_q           <= idx_q + IW'(1);
            end
            if (busy) begin
                if (cfg_seed_ld_i) begin
                    seed_pend_q       <= seed_fix;
                    seed_pend_valid_q <= 1'b1;
                end
            end else begin
                if (cfg_seed_ld_i) begin
                    lfsr_q <= seed_fix;
                end else if (seed_pend_valid_q) begin
                    lfsr_q <= seed_pend_q;
                end
                seed_pend_valid_q <= 1'b0;
            end
        end
    end

    // Lowest-index matching region wins; an inverted window (base > limit) never matches.
    always_comb begin
        logic instr_hit, data_hit;
        logic [ADDR_WIDTH-1:0] base, limit;
        instr_hit    = 1'b0;
        data_hit     = 1'b0;
        instr_addr_o = instr_addr_i;
        data_addr_o  = data_addr_i;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            base  = region_base_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            limit = region_limit_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (cfg_en_i && !instr_hit && base <= instr_addr_i && instr_addr_i <= limit) begin
                instr_hit    = 1'b1;
                instr_addr_o = instr_addr_i + offset_q[k];
            end
            if (cfg_en_i && !data_hit && base <= data_addr_i && data_addr_i <= limit) begin
                data_hit    = 1'b1;
                data_addr_o = data_addr_i + offset_q[k];
            end
        end
    end

    assign instr_stall = busy || (instr_outst_q == CW'(MAX_OUTST));
    assign data_stall  = busy || (data_outst_q == CW'(MAX_OUTST));
    assign instr_req_o = instr_req_i && !instr_stall && !rst;
    assign instr_gnt_o = instr_gnt_i && !instr_stall && !rst;
    assign data_req_o  = data_req_i && !data_stall && !rst;
    assign data_gnt_o  = data_gnt_i && !data_stall && !rst;
    assign instr_inc   = instr_req_o && instr_gnt_i;
    assign data_inc    = data_req_o && data_gnt_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_outst_q <= '0;
            data_outst_q  <= '0;
        end else begin
            if (instr_inc && !instr_rvalid_i) begin
                instr_outst_q <= instr_outst_q + CW'(1);
            end else if (!instr_inc && instr_rvalid_i && instr_outst_q != '0) begin
                instr_outst_q <= instr_outst_q - CW'(1);
            end
            if (data_inc && !data_rvalid_i) begin
                data_outst_q <= data_outst_q + CW'(1);
            end else if (!data_inc && data_rvalid_i && data_outst_q != '0) begin
                data_outst_q <= data_outst_q - CW'(1);
            end
        end
    end

endmodule
